dsp48a1_op_sequencer: RTL

Command-side driver for the DSP48A1 slice. Accepts one operation per valid/ready handshake (A, B, C, D, OPMODE, carry-in) and drives the slice's operand and control inputs. Holds those inputs stable for the slice's pipeline latency, then captures P and CarryOutF and returns them on a valid/ready result port. Sits between a host or microsequencer and the DSP48A1 instance; only one operation is in flight at a time.

---
 rtl/dsp48a1_op_sequencer_pkg.sv | 27 ++
 rtl/dsp48a1_op_sequencer_if.sv | 53 +++++
 rtl/dsp48a1_op_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/dsp48a1_op_sequencer_pkg.sv
// Shared widths, OPMODE field positions and sequencer state type for the DSP48A1 op sequencer.
package dsp48a1_pkg;

    localparam int A_W   = 18;
    localparam int C_W   = 48;
    localparam int OPM_W = 8;

    // Counter must hold PIPE_LAT+1 and INIT_CYCLES, both at most 16.
    localparam int CNT_W = 5;

    localparam int OPM_X_LSB      = 0;
    localparam int OPM_X_MSB      = 1;
    localparam int OPM_Z_LSB      = 2;
    localparam int OPM_Z_MSB      = 3;
    localparam int OPM_PREADD_EN  = 4;
    localparam int OPM_CIN_SEL    = 5;
    localparam int OPM_PREADD_SUB = 6;
    localparam int OPM_POST_SUB   = 7;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } seqState_t;

endpackage

// File: rtl/dsp48a1_op_sequencer_if.sv
// Command, slice-side and result signals of the DSP48A1 op sequencer.
// slave = the sequencer itself; master = host plus slice environment.
interface dsp48a1_op_sequencer_if
    import dsp48a1_pkg::*;
    ;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [A_W-1:0]   cmd_A;
    logic [A_W-1:0]   cmd_B;
    logic [C_W-1:0]   cmd_C;
    logic [A_W-1:0]   cmd_D;
    logic [OPM_W-1:0] cmd_OPMODE;
    logic             cmd_carryIn;

    logic [A_W-1:0]   dsp_A;
    logic [A_W-1:0]   dsp_B;
    logic [A_W-1:0]   dsp_D;
    logic [C_W-1:0]   dsp_C;
    logic [C_W-1:0]   dsp_PCIN;
    logic [OPM_W-1:0] dsp_OPMODE;
    logic             dsp_carryIn;
    logic             dsp_CE;
    logic             dsp_RST;
    logic [C_W-1:0]   dsp_P;
    logic             dsp_CarryOutF;

    logic             res_valid;
    logic             res_ready;
    logic [C_W-1:0]   res_P;
    logic             res_carry;

    modport slave (
        input  cmd_valid, cmd_A, cmd_B, cmd_C, cmd_D, cmd_OPMODE, cmd_carryIn,
        output cmd_ready,
        output dsp_A, dsp_B, dsp_D, dsp_C, dsp_PCIN, dsp_OPMODE, dsp_carryIn,
        output dsp_CE, dsp_RST,
        input  dsp_P, dsp_CarryOutF,
        output res_valid, res_P, res_carry,
        input  res_ready
    );

    modport master (
        output cmd_valid, cmd_A, cmd_B, cmd_C, cmd_D, cmd_OPMODE, cmd_carryIn,
        input  cmd_ready,
        input  dsp_A, dsp_B, dsp_D, dsp_C, dsp_PCIN, dsp_OPMODE, dsp_carryIn,
        input  dsp_CE, dsp_RST,
        output dsp_P, dsp_CarryOutF,
        input  res_valid, res_P, res_carry,
        output res_ready
    );

endinterface

// File: rtl/dsp48a1_op_sequencer.sv
// Drives one DSP48A1 operation at a time and returns the captured P/CarryOutF.
// Optional macro DSP_PCIN_FEEDBACK_EN feeds each captured P back onto PCIN.
module dsp48a1_op_sequencer
    import dsp48a1_pkg::*;
#(
    parameter int PIPE_LAT    = 4,
    parameter int INIT_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    RST,
    dsp48a1_op_sequencer_if.slave   bus
);

    seqState_t        r_state;
    seqState_t        w_nextState;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nextCnt;
    logic             w_accept;
    logic             w_capture;

    logic [A_W-1:0]   r_A;
    logic [A_W-1:0]   r_B;
    logic [A_W-1:0]   r_D;
    logic [C_W-1:0]   r_C;
    logic [OPM_W-1:0] r_opmode;
    logic             r_carryIn;
    logic [C_W-1:0]   r_resP;
    logic             r_resCarry;

    // The count loaded on accept is one more than the slice latency so P has settled when sampled.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            INIT: begin
                w_nextCnt = r_cnt - CNT_W'(1);
                if (r_cnt <= CNT_W'(1)) begin
                    w_nextState = IDLE;
                end
            end
            IDLE: begin
                if (bus.cmd_valid) begin
                    w_accept    = 1'b1;
                    w_nextState = WAIT;
                    w_nextCnt   = CNT_W'(PIPE_LAT + 1);
                end
            end
            WAIT: begin
                w_nextCnt = r_cnt - CNT_W'(1);
                if (r_cnt <= CNT_W'(1)) begin
                    w_capture   = 1'b1;
                    w_nextState = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = INIT;
                w_nextCnt   = CNT_W'(INIT_CYCLES);
            end
        endcase
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state    <= INIT;
            r_cnt      <= CNT_W'(INIT_CYCLES);
            r_A        <= '0;
            r_B        <= '0;
            r_D        <= '0;
            r_C        <= '0;
            r_opmode   <= '0;
            r_carryIn  <= 1'b0;
            r_resP     <= '0;
            r_resCarry <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
            if (w_accept) begin
                r_A       <= bus.cmd_A;
                r_B       <= bus.cmd_B;
                r_D       <= bus.cmd_D;
                r_C       <= bus.cmd_C;
                r_opmode  <= bus.cmd_OPMODE;
                r_carryIn <= bus.cmd_carryIn;
            end
            if (w_capture) begin
                r_resP     <= bus.dsp_P;
                r_resCarry <= bus.dsp_CarryOutF;
            end
        end
    end

`ifdef DSP_PCIN_FEEDBACK_EN
    logic [C_W-1:0] r_pcin;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_pcin <= '0;
        end else if (w_capture) begin
            r_pcin <= bus.dsp_P;
        end
    end

    assign bus.dsp_PCIN = r_pcin;
`else
    assign bus.dsp_PCIN = '0;
`endif

    assign bus.dsp_A       = r_A;
    assign bus.dsp_B       = r_B;
    assign bus.dsp_D       = r_D;
    assign bus.dsp_C       = r_C;
    assign bus.dsp_OPMODE  = r_opmode;
    assign bus.dsp_carryIn = r_carryIn;
    assign bus.res_P       = r_resP;
    assign bus.res_carry   = r_resCarry;

    // CE is held low while RST is asserted even though the state already reads INIT.
    assign bus.cmd_ready = (r_state == IDLE);
    assign bus.res_valid = (r_state == DONE);
    assign bus.dsp_RST   = (r_state == INIT);
    assign bus.dsp_CE    = ((r_state == INIT) && !RST) || (r_state == WAIT);

endmodule
